fp16_dot_accum: RTL and testbench
=================================

Name: fp16_dot_accum

Overview:
Parametrised, streaming FP16 dot-product engine. It has LANES independent lanes. Each lane computes sum(a[k]*b[k]) over a vector of any length. Input beats arrive on a valid/ready stream, and the final sums leave on a second valid/ready stream. Each lane uses one fp16_multiplier and one fp16_adder as pipelined units, so the block replaces the single-shot multiply-add with a self-accumulating, hazard-free engine that sits between the operand buffers and the result writeback.

Parameters:
- LANES, 4, number of parallel lanes.
- MUL_LAT, 2, fp16_multiplier pipeline depth in cycles; must equal the depth of the instantiated unit.
- ADD_LAT, 2, fp16_adder pipeline depth in cycles (≥1); must equal the depth of the instantiated unit.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the input beat is valid.
- in_ready  out  1  the block can accept a beat.
- in_last  in  1  this beat is the final element of the vector.
- a_vec  in  16*LANES  lane i operand a is at bits [16i+15:16i].
- b_vec  in  16*LANES  lane i operand b, same packing as a_vec.
- out_valid  out  1  out_vec holds the finished dot products.
- out_ready  in  1  the consumer accepts out_vec.
- out_vec  out  16*LANES  lane i result, same packing as a_vec.
- busy  out  1  the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, out_valid=0, out_vec=0, busy=0.
  - All partial-sum slots = 16'h0000.
  - The slot pointer and all pipeline valid bits are 0.
  - in_ready=1 from the first cycle after reset.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - The result is delivered when out_valid && out_ready.
  - in_ready=1 only in IDLE and ACCUM.
- FSM states and transitions:
  - IDLE: an accepted beat goes to ACCUM; if that beat has in_last=1, go directly to DRAIN.
  - ACCUM: accept beats. An accepted beat with in_last=1 goes to DRAIN. Idle cycles (in_valid=0) keep the state.
  - DRAIN: wait until the multiplier and adder pipelines are empty, exactly MUL_LAT+ADD_LAT cycles, then go to REDUCE.
  - REDUCE: fold the slots sequentially, acc=slot0, then acc=acc+slot_k for k=1..ADD_LAT-1. Each add takes ADD_LAT cycles, so the state lasts ADD_LAT*(ADD_LAT-1) cycles; with ADD_LAT=1 it lasts 0 cycles. Then go to DONE.
  - DONE: out_valid=1 and out_vec is held stable. On out_ready, go to IDLE in the next cycle, where out_valid=0.
- Latency: out_valid rises exactly MUL_LAT + ADD_LAT*ADD_LAT + 1 cycles after the cycle in which the in_last beat is accepted. With the default parameters this is 7 cycles.
- Accumulation slots:
  - Each lane keeps ADD_LAT partial-sum slots.
  - Accepted beat number j, counted from 0 within the vector, goes to slot j mod ADD_LAT.
  - The first ADD_LAT beats of a vector use +0 (16'h0000) as the slot operand, never a stale value.
- Forwarding: if the adder writes back slot s in the same cycle that a new product for slot s issues, the adder's output is used directly as the operand. This avoids a read-before-write hazard when beats are back-to-back.
- Arithmetic:
  - Rounding, NaN, Inf and subnormal handling come from fp16_multiplier and fp16_adder; no additional rounding.
  - The summation order is fixed, per-slot sums and then slot0..slotN-1, so results are deterministic for a given beat pattern.
- Zero-length vectors cannot occur; every vector has at least one beat ending with in_last.
- Back-to-back vectors: a new vector is accepted in IDLE, the cycle after the DONE handshake.
- Reset mid-operation: rst in any state returns all outputs and registers to their reset values in the next cycle. In-flight pipeline results are discarded, because the valid bits are cleared and late results are never written.

Decomposition:
- Package fp16_dot_pkg holds:
  - FP16_W=16 and FP16_POS_ZERO=16'h0000.
  - The state enum IDLE/ACCUM/DRAIN/REDUCE/DONE.
  - A lane-slice helper function.
- Sub-module fp16_dot_lane holds one lane: multiplier, adder, slot registers, forwarding mux, and reduce accumulator.
- The top level holds the FSM, the slot pointer, the pipeline valid shift registers, and the handshake, all shared by every lane.

Test Plan:
1. LANES=1, single beat a=16'h4000 (2.0), b=16'h4200 (3.0), in_last=1 → out_vec=16'h4600 (6.0), out_valid exactly 7 cycles after acceptance.
2. Four back-to-back beats a=16'h3C00, b=16'h4000 → 16'h4800 (8.0). Checks the forwarding path and slot interleave.
3. Beats with products 1,2,3,4 (a=16'h3C00, b=16'h3C00/4000/4200/4400) and random 0-3 idle cycles between them → 16'h4900 (10.0).
4. out_ready held low for 5 cycles in DONE → out_valid stays 1, out_vec stays stable, in_ready=0. A new vector is accepted the cycle after the handshake.
5. rst asserted in the middle of ACCUM after 2 beats → next cycle out_valid=0 and busy=0. A fresh vector [2.0*3.0] then returns exactly 16'h4600, with no residue.
6. LANES=4 with per-lane products (1*1, 2*2, 0.5*4, -1*3) over one beat → out_vec lanes = 16'h3C00, 16'h4400, 16'h4000, 16'hC200.

Source files
------------

// File: rtl/fp16_dot_pkg.sv
// Shared types, constants and FP16 arithmetic helpers for the FP16 dot-product engine.
// fp16_pack performs the single round-to-nearest-even step used by both multiplier and adder.
package fp16_dot_pkg;

   localparam int unsigned        FP16_W        = 16;
   localparam logic [FP16_W-1:0]  FP16_POS_ZERO = 16'h0000;
   localparam logic [FP16_W-1:0]  FP16_QNAN     = 16'h7E00;

   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, DONE} state_t;

   function automatic int unsigned lane_lsb(input int unsigned lane);
      return lane * FP16_W;
   endfunction

   // Encodes mag * 2^scale as FP16, rounding once to nearest-even.
   function automatic logic [15:0] fp16_pack(input logic sign, input int scale, input logic [47:0] mag);
      int          msb, lsb_exp, shift, biased;
      logic [63:0] wide, keep, rem, half;
      msb = 0;
      for (int unsigned i = 0; i < 48; i++)
         if (mag[i]) msb = int'(i);
      lsb_exp = msb + scale - 10;
      if (lsb_exp < -24) lsb_exp = -24;
      shift = lsb_exp - scale;
      wide  = {16'h0000, mag};
      rem   = '0;
      half  = '0;
      if (shift <= 0) keep = wide << (-shift);
      else if (shift >= 64) keep = '0;
      else begin
         keep = wide >> shift;
         rem  = wide & ((64'd1 << shift) - 64'd1);
         half = 64'd1 << (shift - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      end
      if (keep[11]) begin
         keep    = keep >> 1;
         lsb_exp = lsb_exp + 1;
      end
      biased = keep[10] ? lsb_exp + 25 : 0;
      if (mag == '0) return {sign, 15'h0000};
      if (biased >= 31) return {sign, 5'h1f, 10'h000};
      return {sign, biased[4:0], keep[9:0]};
   endfunction

   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [10:0] sa, sb;
      logic [21:0] p;
      int          ea, eb;
      sign   = a[15] ^ b[15];
      a_nan  = (&a[14:10]) && (|a[9:0]);
      b_nan  = (&b[14:10]) && (|b[9:0]);
      a_inf  = (&a[14:10]) && !(|a[9:0]);
      b_inf  = (&b[14:10]) && !(|b[9:0]);
      a_zero = (a[14:0] == 15'h0000);
      b_zero = (b[14:0] == 15'h0000);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP16_QNAN;
      if (a_inf || b_inf) return {sign, 5'h1f, 10'h000};
      sa = {|a[14:10], a[9:0]};
      sb = {|b[14:10], b[9:0]};
      ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
      eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
      p  = 22'(sa) * 22'(sb);
      return fp16_pack(sign, ea + eb - 50, {26'h0, p});
   endfunction

   // Aligns both operands exactly, adds, then rounds once.
   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf;
      logic [47:0] ma, mb;
      int          ea, eb, emin;
      a_nan = (&a[14:10]) && (|a[9:0]);
      b_nan = (&b[14:10]) && (|b[9:0]);
      a_inf = (&a[14:10]) && !(|a[9:0]);
      b_inf = (&b[14:10]) && !(|b[9:0]);
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return FP16_QNAN;
      if (a_inf) return a;
      if (b_inf) return b;
      ea   = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
      eb   = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
      emin = (ea < eb) ? ea : eb;
      ma   = 48'({|a[14:10], a[9:0]}) << (ea - emin);
      mb   = 48'({|b[14:10], b[9:0]}) << (eb - emin);
      if (a[15] == b[15]) return fp16_pack(a[15], emin - 25, ma + mb);
      if (ma > mb) return fp16_pack(a[15], emin - 25, ma - mb);
      if (mb > ma) return fp16_pack(b[15], emin - 25, mb - ma);
      return FP16_POS_ZERO;
   endfunction

endpackage

// File: rtl/fp16_dot_lane.sv
// One dot-product lane: pipelined FP16 multiplier and adder, ADD_LAT partial-sum slots
// with write-back forwarding, and the final reduction result register.
module fp16_multiplier import fp16_dot_pkg::*; #(
   parameter int unsigned LAT = 2
) (
   input  logic              clk,
   input  logic [FP16_W-1:0] a,
   input  logic [FP16_W-1:0] b,
   output logic [FP16_W-1:0] p
);
   logic [FP16_W-1:0] pipe [LAT];

   always_ff @(posedge clk) begin
      pipe[0] <= fp16_mul(a, b);
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign p = pipe[LAT-1];
endmodule

module fp16_adder import fp16_dot_pkg::*; #(
   parameter int unsigned LAT = 2
) (
   input  logic              clk,
   input  logic [FP16_W-1:0] a,
   input  logic [FP16_W-1:0] b,
   output logic [FP16_W-1:0] s
);
   logic [FP16_W-1:0] pipe [LAT];

   always_ff @(posedge clk) begin
      pipe[0] <= fp16_add(a, b);
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign s = pipe[LAT-1];
endmodule

module fp16_dot_lane import fp16_dot_pkg::*; #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned SW      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FP16_W-1:0] a,
   input  logic [FP16_W-1:0] b,
   input  logic              slot_clr,
   input  logic              prod_valid,
   input  logic [SW-1:0]     prod_slot,
   input  logic              prod_first,
   input  logic              wr_en,
   input  logic [SW-1:0]     wr_slot,
   input  logic              fold_issue,
   input  logic              fold_first,
   input  logic [SW-1:0]     fold_slot,
   input  logic              res_load,
   output logic [FP16_W-1:0] res
);
   logic [FP16_W-1:0] prod, sum, add_x, add_y;
   logic [FP16_W-1:0] slot  [ADD_LAT];
   logic [FP16_W-1:0] slotf [ADD_LAT];

   fp16_multiplier #(.LAT(MUL_LAT)) u_mul (.clk(clk), .a(a), .b(b), .p(prod));
   fp16_adder      #(.LAT(ADD_LAT)) u_add (.clk(clk), .a(add_x), .b(add_y), .s(sum));

   // Slot view with the adder's same-cycle write-back forwarded.
   always_comb begin
      for (int unsigned s = 0; s < ADD_LAT; s++)
         slotf[s] = (wr_en && wr_slot == SW'(s)) ? sum : slot[s];
   end

   always_comb begin
      add_x = FP16_POS_ZERO;
      add_y = FP16_POS_ZERO;
      if (prod_valid) begin
         add_x = prod;
         add_y = prod_first ? FP16_POS_ZERO : slotf[prod_slot];
      end else if (fold_issue) begin
         add_x = fold_first ? slotf[0] : sum;
         add_y = slotf[fold_slot];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < ADD_LAT; s++) slot[s] <= FP16_POS_ZERO;
         res <= '0;
      end else begin
         if (slot_clr) begin
            for (int unsigned s = 0; s < ADD_LAT; s++) slot[s] <= FP16_POS_ZERO;
         end else if (wr_en) begin
            slot[wr_slot] <= sum;
         end
         if (res_load) res <= (ADD_LAT == 1) ? slotf[0] : sum;
      end
   end
endmodule

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 dot-product engine: shared FSM, slot pointer, pipeline valid tracking
// and handshakes driving LANES identical lanes.
module fp16_dot_accum import fp16_dot_pkg::*; #(
   parameter int unsigned LANES   = 4,
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned ADD_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic [FP16_W*LANES-1:0] a_vec,
   input  logic [FP16_W*LANES-1:0] b_vec,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [FP16_W*LANES-1:0] out_vec,
   output logic                    busy
);
   localparam int unsigned SW         = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam int unsigned DRAIN_CYC  = MUL_LAT + ADD_LAT;
   localparam int unsigned REDUCE_CYC = ADD_LAT * (ADD_LAT - 1);
   localparam int unsigned CW         = $clog2(DRAIN_CYC + REDUCE_CYC + 1) + 1;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [SW-1:0] ptr, ph;
   logic [SW:0]   kslot;
   logic          firstlap;
   logic          mv_v [MUL_LAT];
   logic          mv_f [MUL_LAT];
   logic [SW-1:0] mv_s [MUL_LAT];
   logic          av_v [ADD_LAT];
   logic [SW-1:0] av_s [ADD_LAT];
   logic          accept, drain_last, reduce_last;
   logic          fold_first, fold_issue, res_load;
   logic [SW-1:0] fold_slot;

   assign in_ready    = (state == IDLE) || (state == ACCUM);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign accept      = in_valid && in_ready;
   assign drain_last  = (state == DRAIN) && (cnt == CW'(DRAIN_CYC - 1));
   assign reduce_last = (state == REDUCE) && (cnt == CW'(REDUCE_CYC - 1));

   // The first fold (slot0 + slot1) issues in the last DRAIN cycle so the final sum
   // leaves the adder in the last REDUCE cycle; later folds chain every ADD_LAT cycles.
   assign fold_first = drain_last && (ADD_LAT > 1);
   assign fold_issue = fold_first ||
                       ((state == REDUCE) && (ph == '0) && (kslot < (SW+1)'(ADD_LAT)));
   assign fold_slot  = fold_first ? SW'(1) : kslot[SW-1:0];
   assign res_load   = (ADD_LAT == 1) ? drain_last : reduce_last;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ACCUM: if (accept) state_nx = in_last ? DRAIN : ACCUM;
         DRAIN:       if (drain_last) state_nx = (ADD_LAT > 1) ? REDUCE : DONE;
         REDUCE:      if (reduce_last) state_nx = DONE;
         DONE:        if (out_ready) state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= '0;
         ph       <= '0;
         kslot    <= '0;
         firstlap <= 1'b1;
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            mv_v[i] <= 1'b0;
            mv_f[i] <= 1'b0;
            mv_s[i] <= '0;
         end
         for (int unsigned i = 0; i < ADD_LAT; i++) begin
            av_v[i] <= 1'b0;
            av_s[i] <= '0;
         end
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
         if (accept) begin
            ptr <= (ptr == SW'(ADD_LAT - 1)) ? '0 : ptr + 1'b1;
            if (ptr == SW'(ADD_LAT - 1)) firstlap <= 1'b0;
         end
         if ((state == DONE) && out_ready) begin
            ptr      <= '0;
            firstlap <= 1'b1;
         end
         if (fold_first) begin
            ph    <= SW'(1);
            kslot <= (SW+1)'(2);
         end else if (state == REDUCE) begin
            ph <= (ph == SW'(ADD_LAT - 1)) ? '0 : ph + 1'b1;
            if (fold_issue) kslot <= kslot + 1'b1;
         end
         mv_v[0] <= accept;
         mv_f[0] <= firstlap;
         mv_s[0] <= ptr;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            mv_v[i] <= mv_v[i-1];
            mv_f[i] <= mv_f[i-1];
            mv_s[i] <= mv_s[i-1];
         end
         av_v[0] <= mv_v[MUL_LAT-1];
         av_s[0] <= mv_s[MUL_LAT-1];
         for (int unsigned i = 1; i < ADD_LAT; i++) begin
            av_v[i] <= av_v[i-1];
            av_s[i] <= av_s[i-1];
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp16_dot_lane #(
         .MUL_LAT (MUL_LAT),
         .ADD_LAT (ADD_LAT),
         .SW      (SW)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .a          (a_vec[lane_lsb(i) +: FP16_W]),
         .b          (b_vec[lane_lsb(i) +: FP16_W]),
         .slot_clr   (accept && (state == IDLE)),
         .prod_valid (mv_v[MUL_LAT-1]),
         .prod_slot  (mv_s[MUL_LAT-1]),
         .prod_first (mv_f[MUL_LAT-1]),
         .wr_en      (av_v[ADD_LAT-1]),
         .wr_slot    (av_s[ADD_LAT-1]),
         .fold_issue (fold_issue),
         .fold_first (fold_first),
         .fold_slot  (fold_slot),
         .res_load   (res_load),
         .res        (out_vec[lane_lsb(i) +: FP16_W])
      );
   end
endmodule

// File: tb/tb_fp16_dot_accum.sv
// Randomized self-checking bench for fp16_dot_accum; operands are chosen so every partial
// sum is exact in FP16, letting a real-valued model predict results independent of order.
module tb_fp16_dot_accum;
   localparam int L       = 4;
   localparam int MUL_LAT = 2;
   localparam int ADD_LAT = 2;
   localparam int LAT_EXP = MUL_LAT + ADD_LAT * ADD_LAT + 1;

   logic            clk = 1'b0;
   logic            rst, in_valid, in_ready, in_last, out_valid, out_ready, busy;
   logic [16*L-1:0] a_vec, b_vec, out_vec;

   int checks = 0;
   int errors = 0;

   logic [16*L-1:0] va[$];
   logic [16*L-1:0] vb[$];
   logic [16*L-1:0] res_vec;
   logic [15:0]     codes [6] = '{16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 16'h4400};

   fp16_dot_accum #(
      .LANES   (L),
      .MUL_LAT (MUL_LAT),
      .ADD_LAT (ADD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic real fp_val(input logic [15:0] h);
      real m;
      int  e;
      if (h[14:0] == 15'h0000) return 0.0;
      m = 1.0 + real'(h[9:0]) / 1024.0;
      e = int'(h[14:10]) - 15;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return h[15] ? -m : m;
   endfunction

   function automatic logic [15:0] to_fp16(input real r);
      real m;
      int  e, frac;
      if (r == 0.0) return 16'h0000;
      m = (r < 0.0) ? -r : r;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      frac = $rtoi((m - 1.0) * 1024.0);
      return {r < 0.0, 5'(e + 15), 10'(frac)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] c;
      c     = codes[$urandom_range(5, 0)];
      c[15] = ($urandom_range(1, 0) != 0);
      return c;
   endfunction

   function automatic logic [15:0] model_lane(input int lane);
      real s = 0.0;
      for (int k = 0; k < va.size(); k++)
         s = s + fp_val(va[k][16*lane +: 16]) * fp_val(vb[k][16*lane +: 16]);
      return to_fp16(s);
   endfunction

   function automatic logic [16*L-1:0] splat(input logic [15:0] v);
      logic [16*L-1:0] r;
      for (int i = 0; i < L; i++) r[16*i +: 16] = v;
      return r;
   endfunction

   task automatic send_beat(input logic [16*L-1:0] a, input logic [16*L-1:0] b, input logic last);
      int guard = 0;
      in_valid = 1'b1;
      a_vec    = a;
      b_vec    = b;
      in_last  = last;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input int hold, output int lat);
      logic [16*L-1:0] held;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      held    = out_vec;
      res_vec = out_vec;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_out_vec", out_vec, held);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask

   task automatic run_vec(input int hold, input int max_idle, input string name);
      logic [15:0] exp_l [L];
      int          lat;
      for (int i = 0; i < L; i++) exp_l[i] = model_lane(i);
      for (int k = 0; k < va.size(); k++) begin
         for (int w = 0; w < int'($urandom_range(max_idle, 0)); w++) begin
            @(posedge clk); #1;
         end
         send_beat(va[k], vb[k], k == va.size() - 1);
      end
      collect(hold, lat);
      check($sformatf("%s_latency", name), lat, LAT_EXP);
      for (int i = 0; i < L; i++)
         check($sformatf("%s_lane%0d", name, i), res_vec[16*i +: 16], exp_l[i]);
   endtask

   initial begin
      logic [16*L-1:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      a_vec = '0; b_vec = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_vec", out_vec, 0);

      // single beat 2.0*3.0
      va.delete(); vb.delete();
      ra = '0; rb = '0;
      for (int i = 1; i < L; i++) begin ra[16*i +: 16] = rand_op(); rb[16*i +: 16] = rand_op(); end
      ra[15:0] = 16'h4000; rb[15:0] = 16'h4200;
      va.push_back(ra); vb.push_back(rb);
      run_vec(0, 0, "single");
      check("single_const", res_vec[15:0], 16'h4600);

      // four back-to-back 1.0*2.0
      va.delete(); vb.delete();
      for (int k = 0; k < 4; k++) begin va.push_back(splat(16'h3C00)); vb.push_back(splat(16'h4000)); end
      run_vec(0, 0, "b2b");
      check("b2b_const", res_vec[15:0], 16'h4800);

      // products 1,2,3,4 with random gaps
      va.delete(); vb.delete();
      va.push_back(splat(16'h3C00)); vb.push_back(splat(16'h3C00));
      va.push_back(splat(16'h3C00)); vb.push_back(splat(16'h4000));
      va.push_back(splat(16'h3C00)); vb.push_back(splat(16'h4200));
      va.push_back(splat(16'h3C00)); vb.push_back(splat(16'h4400));
      run_vec(0, 3, "gaps");
      check("gaps_const", res_vec[15:0], 16'h4900);

      // consumer stall for 5 cycles
      va.delete(); vb.delete();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < L; i++) begin ra[16*i +: 16] = rand_op(); rb[16*i +: 16] = rand_op(); end
         va.push_back(ra); vb.push_back(rb);
      end
      run_vec(5, 0, "stall");

      // reset in ACCUM after two beats
      send_beat(splat(16'h4400), splat(16'h4400), 1'b0);
      send_beat(splat(16'h4200), splat(16'h4200), 1'b0);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_vec", out_vec, 0);
      va.delete(); vb.delete();
      va.push_back(splat(16'h4000)); vb.push_back(splat(16'h4200));
      run_vec(0, 0, "after_rst");
      check("after_rst_const", res_vec[15:0], 16'h4600);

      // per-lane single beat
      va.delete(); vb.delete();
      va.push_back({16'hBC00, 16'h3800, 16'h4000, 16'h3C00});
      vb.push_back({16'h4200, 16'h4400, 16'h4000, 16'h3C00});
      run_vec(1, 0, "lanes");
      check("lanes_const", res_vec, 64'hC200_4000_4400_3C00);

      // random vectors
      for (int n = 0; n < 25; n++) begin
         va.delete(); vb.delete();
         for (int k = 0; k < int'($urandom_range(8, 1)); k++) begin
            for (int i = 0; i < L; i++) begin ra[16*i +: 16] = rand_op(); rb[16*i +: 16] = rand_op(); end
            va.push_back(ra); vb.push_back(rb);
         end
         run_vec(int'($urandom_range(3, 0)), 2, $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1, "timeout");
   end
endmodule
